// File: rtl/bist_initiator.sv
// bist_initiator: sequences one BIST session per request. Raises bist_start,
// waits for bist_end, a timeout or an abort, drops bist_start for a fixed gap,
// then reports the verdict and updates the saturating run/fail counters.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for req; bist_start low, busy low
// ARM        | bist_start raised, timeout timer loaded
// WAIT_END   | waiting for bist_end / abort / timer terminal count
// RELEASE    | bist_start low for GAP_CYCLES cycles
// REPORT     | done pulse, verdict and counters updated
// WAIT_LOW   | waits for req and bist_end low so a held req cannot retrigger
module bist_initiator #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int GAP_CYCLES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic       abort,
  input  logic       bist_end,
  input  logic       pass_nfail,
  output logic       bist_start,
  output logic       busy,
  output logic       done,
  output logic       result_pass,
  output logic       timeout_err,
  output logic       aborted,
  output logic [7:0] run_count,
  output logic [7:0] fail_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_END,
    S_RELEASE,
    S_REPORT,
    S_WAIT_LOW
  } state_t;

  // The timer counts down the remaining WAIT_END cycles; reaching zero in
  // WAIT_END is the same instant an up-counter would hit TIMEOUT_CYCLES-1.
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [15:0] timer;
  logic [3:0]  gap_cnt;
  logic        flag_pass;
  logic        flag_timeout;
  logic        flag_abort;

  // Session FSM with all outputs registered; done defaults low so it pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      timer        <= '0;
      gap_cnt      <= '0;
      flag_pass    <= 1'b0;
      flag_timeout <= 1'b0;
      flag_abort   <= 1'b0;
      bist_start   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_pass  <= 1'b0;
      timeout_err  <= 1'b0;
      aborted      <= 1'b0;
      run_count    <= '0;
      fail_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state        <= S_ARM;
            bist_start   <= 1'b1;
            busy         <= 1'b1;
            flag_pass    <= 1'b0;
            flag_timeout <= 1'b0;
            flag_abort   <= 1'b0;
          end
        end

        S_ARM: begin
          timer <= TIMER_LOAD;
          if (abort) begin
            flag_abort <= 1'b1;
            bist_start <= 1'b0;
            gap_cnt    <= GAP_LOAD;
            state      <= S_RELEASE;
          end else begin
            state <= S_WAIT_END;
          end
        end

        S_WAIT_END: begin
          // abort wins over a simultaneous bist_end, whose verdict is dropped
          if (abort) begin
            flag_abort <= 1'b1;
            bist_start <= 1'b0;
            gap_cnt    <= GAP_LOAD;
            state      <= S_RELEASE;
          end else if (bist_end) begin
            flag_pass  <= pass_nfail;
            bist_start <= 1'b0;
            gap_cnt    <= GAP_LOAD;
            state      <= S_RELEASE;
          end else if (timer == 16'd0) begin
            flag_timeout <= 1'b1;
            flag_pass    <= 1'b0;
            bist_start   <= 1'b0;
            gap_cnt      <= GAP_LOAD;
            state        <= S_RELEASE;
          end else begin
            timer <= timer - 16'd1;
          end
        end

        S_RELEASE: begin
          if (gap_cnt == 4'd0) begin
            state       <= S_REPORT;
            done        <= 1'b1;
            result_pass <= flag_pass;
            timeout_err <= flag_timeout;
            aborted     <= flag_abort;
            if (!flag_abort && run_count != 8'hFF)
              run_count <= run_count + 8'd1;
            if (!flag_abort && (!flag_pass || flag_timeout) && fail_count != 8'hFF)
              fail_count <= fail_count + 8'd1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end

        S_REPORT: begin
          state <= S_WAIT_LOW;
        end

        S_WAIT_LOW: begin
          if (!req && !bist_end) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state      <= S_IDLE;
          bist_start <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bist_initiator.md
BIST_INITIATOR -- requirements
Module: bist_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000: maximum cycles spent in WAIT_END before a timeout is declared; legal range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 2: cycles bist_start is held low in RELEASE before the result is reported; legal range 1..15.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 req  input  1  level request to run one BIST session; acted on only in IDLE.
REQ-006 abort  input  1  cancels an in-progress session; acted on only in ARM and WAIT_END.
REQ-007 bist_end  input  1  end-of-test indication from the BIST controller.
REQ-008 pass_nfail  input  1  MISR verdict (1 = pass); valid only in the cycle bist_end=1.
REQ-009 bist_start  output  1  start request to the BIST controller; held high for the whole session.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when a session result is reported.
REQ-012 result_pass  output  1  verdict of the last reported session.
REQ-013 timeout_err  output  1  the last reported session timed out.
REQ-014 aborted  output  1  the last reported session was aborted.
REQ-015 run_count  output  8  number of completed, non-aborted sessions; saturates at 255.
REQ-016 fail_count  output  8  number of failed or timed-out sessions; saturates at 255.

Function
REQ-017 The FSM SHALL have six states: IDLE, ARM, WAIT_END, RELEASE, REPORT and WAIT_LOW, with all outputs registered.
REQ-018 IDLE: bist_start=0; on req=1, the FSM SHALL go to ARM and clear the internal status flags.
REQ-019 ARM: bist_start=1 and timer=0; the FSM SHALL go to WAIT_END, or to RELEASE with the abort flag set if abort=1.
REQ-020 WAIT_END: bist_start=1 and the timer increments each cycle; the FSM SHALL resolve events in the following priority order.
- abort=1: set the abort flag and go to RELEASE.
- bist_end=1: capture pass_nfail into the pass flag and go to RELEASE.
- timer = TIMEOUT_CYCLES-1: set the timeout flag, clear the pass flag, and go to RELEASE.
REQ-021 If abort and bist_end are high in the same cycle, the FSM SHALL treat the session as aborted and SHALL discard the verdict.
REQ-022 RELEASE: bist_start=0 for exactly GAP_CYCLES cycles, then the FSM SHALL go to REPORT.
REQ-023 REPORT, one cycle:
- done=1;
- result_pass, timeout_err and aborted SHALL load from the internal flags;
- run_count SHALL increment unless the session was aborted;
- fail_count SHALL increment if the session was not aborted and either the pass flag is 0 or the timeout flag is 1.
REQ-024 Neither counter SHALL wrap: at 255 each SHALL hold its value.
REQ-025 After REPORT the FSM SHALL go to WAIT_LOW and stay there until req=0 and bist_end=0, then go to IDLE; a held-high req therefore SHALL NOT retrigger a session.
REQ-026 A req asserted while busy=1 SHALL be ignored.
REQ-027 result_pass, timeout_err and aborted SHALL hold their values until the next REPORT.
REQ-028 Latency: bist_start SHALL rise 1 cycle after req is sampled in IDLE, and done SHALL pulse GAP_CYCLES+1 cycles after the bist_end cycle.
REQ-029 bist_end=1 in any state other than WAIT_END SHALL be ignored.

Reset
REQ-030 While reset=0 at a rising clock edge, the FSM SHALL go to IDLE, the timer SHALL clear to 0, and all outputs SHALL clear to 0 (bist_start, busy, done, result_pass, timeout_err, aborted, run_count, fail_count).
REQ-031 A reset during any state, including mid-session, SHALL drop bist_start in the following cycle, SHALL produce no done pulse, and SHALL leave both counters at 0.

Verification
REQ-032 The bench SHALL cover the following scenarios.
- Pass run: req=1 for 1 cycle; bist_end=1 with pass_nfail=1 after 50 cycles -> bist_start high for 51 cycles, done after 3 cycles, result_pass=1, run_count=1, fail_count=0.
- Fail run: same as pass run with pass_nfail=0 -> result_pass=0, run_count=1, fail_count=1.
- Timeout: TIMEOUT_CYCLES=100, bist_end held at 0 -> timeout_err=1, result_pass=0, bist_start drops after 100 WAIT_END cycles, fail_count increments.
- Abort: abort=1 on the same cycle as bist_end=1 -> aborted=1, counters unchanged.
- Reset mid-session: reset=0 at WAIT_END cycle 10 -> next cycle bist_start=0, busy=0, no done pulse, then a new req runs normally.
- Held req and saturation: req held high through REPORT -> exactly one session; run 256 sessions -> run_count=255 and no wrap.
